uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, majority-vote bit sampling and a
// first-word-fall-through receive FIFO with sticky frame/overrun flags.
module uart_rx_fifo #(
  parameter int CLKFREQ = 24000000,
  parameter int BAUD    = 115200,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     resetq,
  input  logic                     rx,
  input  logic                     rd,
  input  logic                     clr_err,
  output logic                     valid,
  output logic [7:0]               data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int DIV = CLKFREQ / (16 * BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta;
  logic          rxs;
  logic          rxs_d;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  state_t        state;
  logic [3:0]    tick_idx;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          s7;
  logic          s8;
  logic          maj;
  logic          hold;
  logic          start_edge;
  logic          stop_mid;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          frame_set;
  logic          ovr_set;
  logic [AW:0]   count_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_comb begin
    start_edge = (state == IDLE) && !hold && rxs_d && !rxs;
    tick       = (tick_cnt == TICK_LAST);
    maj        = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
    stop_mid   = tick && (state == STOP) && (tick_idx == 4'd9);
    push       = stop_mid && maj;
    frame_set  = stop_mid && !maj;
    pop        = rd && valid;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    push_ok    = push && ((count != FULL) || pop);
    ovr_set    = push && !push_ok;
    count_nxt  = count;
    if (push_ok && !pop) count_nxt = count + (AW + 1)'(1);
    if (!push_ok && pop) count_nxt = count - (AW + 1)'(1);
  end

  // Oversample divider re-phases on every accepted start edge.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)         tick_cnt <= '0;
    else if (start_edge) tick_cnt <= '0;
    else if (tick)       tick_cnt <= '0;
    else                 tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state    <= IDLE;
      tick_idx <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      hold     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hold && rxs) hold <= 1'b0;
          if (start_edge) begin
            state    <= START;
            tick_idx <= '0;
            bit_idx  <= '0;
          end
        end
        default: begin
          if (tick) begin
            tick_idx <= tick_idx + 4'd1;
            if (tick_idx == 4'd7) s7 <= rxs;
            if (tick_idx == 4'd8) s8 <= rxs;
            case (state)
              START: begin
                if (tick_idx == 4'd9 && maj) state <= IDLE;
                else if (tick_idx == 4'd15)  state <= DATA;
              end
              DATA: begin
                if (tick_idx == 4'd9) shreg <= {maj, shreg[7:1]};
                if (tick_idx == 4'd15) begin
                  if (bit_idx == 3'd7) state <= STOP;
                  bit_idx <= bit_idx + 3'd1;
                end
              end
              STOP: begin
                // leave at mid stop bit; a bad stop holds off until the line idles high
                if (tick_idx == 4'd9) begin
                  state <= IDLE;
                  hold  <= !maj;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      valid <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set | (frame_err & !clr_err);
      overrun   <= ovr_set   | (overrun   & !clr_err);
    end
  end

  assign data = mem[rd_ptr];

endmodule
